pit_packet_store: RTL

- Memory-side responder for the PIT byte-streaming interface.
- Accepts per-entry packet byte streams written by the PIT (start/write-enable/address/data), stores them in slotted on-chip RAM with a per-slot length and valid flag, and replays a stored slot as a byte stream with valid/last framing on request.
- Sits between the PIT controller and the outgoing-face logic.

---
 rtl/pit_packet_store.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/pit_packet_store.sv
// pit_packet_store: slotted packet store between the PIT controller and the
// outgoing-face logic. PIT byte streams (start/write-enable/address/data) are
// written into one of 2^SLOT_W RAM slots with a per-slot length and valid
// flag; a stored slot is replayed on request as a gap-free byte stream with
// valid/last framing.
//
// Optional build macro: PIT_STORE_CONSUME_EN
//   defined   - a slot's valid flag clears when its last byte is issued, so
//               each stored packet can be replayed once.
//   undefined - slots persist until overwritten or reset.
module pit_packet_store #(
    parameter int SLOT_W = 2,
    parameter int BYTE_W = 10,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_start,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     rd_req,
    input  logic [SLOT_W-1:0]        rd_slot,
    output logic                     rd_ack,
    output logic                     rd_err,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     rd_last,
    output logic                     busy,
    output logic                     wr_drop,
    output logic                     wr_ovf,
    output logic [(1<<SLOT_W)-1:0]   slot_valid
);

    localparam int NSLOT = 1 << SLOT_W;
    localparam int DEPTH = 1 << (SLOT_W + BYTE_W);
    localparam int RAW   = SLOT_W + BYTE_W;

    // Largest storable byte count; reaching it means the slot is full.
    localparam logic [BYTE_W-1:0] MAX_CNT = '1;
    localparam logic [BYTE_W-1:0] ONE     = BYTE_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    state_t                         state_q, state_d;
    logic [SLOT_W-1:0]              slot_q, slot_d;
    logic [BYTE_W-1:0]              cnt_q, cnt_d;
    logic [BYTE_W-1:0]              rcnt_q, rcnt_d;
    logic [BYTE_W-1:0]              rlen_q, rlen_d;
    logic [NSLOT-1:0][BYTE_W-1:0]   len_q, len_d;
    logic [NSLOT-1:0]               valid_q, valid_d;

    logic                           rd_ack_q, rd_ack_d;
    logic                           rd_err_q, rd_err_d;
    logic                           rd_valid_q, rd_valid_d;
    logic                           rd_last_q, rd_last_d;
    logic                           wr_drop_q, wr_drop_d;
    logic                           wr_ovf_q, wr_ovf_d;

    logic                           ram_we;
    logic [RAW-1:0]                 ram_waddr;
    logic                           ram_re;
    logic [RAW-1:0]                 ram_raddr;
    logic [7:0]                     ram_rdata;
    logic [7:0]                     mem [DEPTH];

    logic [SLOT_W-1:0]              wr_slot;
    logic                           wr_go;
    logic                           rd_is_last;
    logic                           unused_addr_hi;

    assign wr_slot        = wr_addr[SLOT_W-1:0];
    assign wr_go          = wr_start & wr_en;
    assign unused_addr_hi = ^wr_addr[ADDR_W-1:SLOT_W];

    // True on the READ cycle that issues the final offset of the packet.
    assign rd_is_last = (rcnt_q == (rlen_q - ONE));

    // Next-state, bookkeeping and pulse-output computation for the FSM.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        cnt_d      = cnt_q;
        rcnt_d     = rcnt_q;
        rlen_d     = rlen_q;
        len_d      = len_q;
        valid_d    = valid_q;
        rd_ack_d   = 1'b0;
        rd_err_d   = 1'b0;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        wr_drop_d  = 1'b0;
        wr_ovf_d   = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = {slot_q, cnt_q};
        ram_re     = 1'b0;
        ram_raddr  = {slot_q, rcnt_q};

        unique case (state_q)
            IDLE: begin
                // A write start takes priority; a coincident rd_req stays
                // pending and is serviced once the write commits.
                if (wr_go) begin
                    slot_d           = wr_slot;
                    ram_we           = 1'b1;
                    ram_waddr        = {wr_slot, {BYTE_W{1'b0}}};
                    cnt_d            = ONE;
                    valid_d[wr_slot] = 1'b0;
                    state_d          = WRITE;
                end else if (rd_req) begin
                    if (valid_q[rd_slot]) begin
                        rd_ack_d = 1'b1;
                        slot_d   = rd_slot;
                        rlen_d   = len_q[rd_slot];
                        rcnt_d   = '0;
                        state_d  = READ;
                    end else begin
                        rd_err_d = 1'b1;
                    end
                end
            end

            WRITE: begin
                if (wr_en) begin
                    if (cnt_q != MAX_CNT) begin
                        ram_we = 1'b1;
                        cnt_d  = cnt_q + ONE;
                    end else begin
                        wr_ovf_d = 1'b1;
                    end
                end else begin
                    len_d[slot_q]   = cnt_q;
                    valid_d[slot_q] = 1'b1;
                    state_d         = IDLE;
                end
            end

            READ: begin
                ram_re     = 1'b1;
                rd_valid_d = 1'b1;
                rcnt_d     = rcnt_q + ONE;
                if (rd_is_last) begin
                    rd_last_d = 1'b1;
                    state_d   = IDLE;
`ifdef PIT_STORE_CONSUME_EN
                    valid_d[slot_q] = 1'b0;
`endif
                end
                if (wr_go) begin
                    wr_drop_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, slot bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            cnt_q      <= '0;
            rcnt_q     <= '0;
            rlen_q     <= '0;
            len_q      <= '0;
            valid_q    <= '0;
            rd_ack_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            wr_drop_q  <= 1'b0;
            wr_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            rcnt_q     <= rcnt_d;
            rlen_q     <= rlen_d;
            len_q      <= len_d;
            valid_q    <= valid_d;
            rd_ack_q   <= rd_ack_d;
            rd_err_q   <= rd_err_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            wr_drop_q  <= wr_drop_d;
            wr_ovf_q   <= wr_ovf_d;
        end
    end

    // Packet RAM: single write port, registered read port, contents not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= wr_data;
        end
        if (ram_re) begin
            ram_rdata <= mem[ram_raddr];
        end
    end

    // The RAM read register has no reset, so rd_data is qualified by
    // rd_valid to keep it at zero outside a replay and after reset.
    assign rd_data    = rd_valid_q ? ram_rdata : '0;
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
    assign rd_ack     = rd_ack_q;
    assign rd_err     = rd_err_q;
    assign wr_drop    = wr_drop_q;
    assign wr_ovf     = wr_ovf_q;
    assign busy       = (state_q != IDLE);
    assign slot_valid = valid_q;

endmodule
